cpu_clock_ctrl: RTL and testbench

- Parametrised CPU clock and reset controller between the board clock clk50M and the CPU core.
- Generates a divided clk_cpu with free-run, single-step, N-cycle burst and halt modes.
- Debounces the manual step button.
- Generates a CPU reset that is stretched over a configurable number of clk_cpu rising edges, asserted on rst and on any rom_sel change.
- Exports a clk_cpu rising-edge strobe and a wrapping cycle counter for the monitor display.

---
 rtl/cpu_clk_pkg.sv | 17 +
 rtl/btn_debounce.sv | 41 ++++
 rtl/cpu_clock_ctrl.sv | 150 +++++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared mode and FSM state encodings for cpu_clock_ctrl
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_HALT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_PARK = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stability counter for a raw button
module btn_debounce #(
  parameter int CYCLES = 65536
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // The counter only runs while the synchronised input disagrees with the accepted level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CYCLES - 1)) begin
        r_level <= r_sync1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - divided CPU clock with run/step/burst/halt modes and stretched CPU reset
import cpu_clk_pkg::*;

module cpu_clock_ctrl #(
  parameter int DIV_W           = 25,
  parameter int BURST_W         = 16,
  parameter int CNT_W           = 32,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int RST_EDGES       = 4
) (
  input  logic               clk50M,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div_value,
  input  logic               step_btn,
  input  logic               burst_go,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               rom_sel,
  output logic               clk_cpu,
  output logic               cpu_tick,
  output logic               cpu_rst,
  output logic               busy,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int RW = $clog2(RST_EDGES + 1);

  state_e             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_hc, w_hc_nxt;
  logic               r_clk, w_clk_nxt;
  logic               r_tick, w_tick_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_step_pend, w_step_pend_nxt;
  logic [BURST_W-1:0] r_burst_rem, w_burst_rem_nxt;
  logic [RW-1:0]      r_rst_cnt, w_rst_cnt_nxt;
  logic               r_cpu_rst;
  logic               r_rom_q;
  logic               r_btn_q;
  logic               w_btn_level;
  logic               w_btn_rise;
  logic               w_go;
  logic               w_phase_done;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .i_clk   (clk50M),
    .i_rst   (rst),
    .i_btn   (step_btn),
    .o_level (w_btn_level)
  );

  assign w_btn_rise   = w_btn_level & ~r_btn_q;
  assign w_go         = (mode == MODE_RUN) | r_step_pend | (r_burst_rem != '0);
  assign w_phase_done = (r_hc >= div_value);

  always_comb begin
    w_state_nxt     = r_state;
    w_hc_nxt        = r_hc + DIV_W'(1);
    w_clk_nxt       = r_clk;
    w_tick_nxt      = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_step_pend_nxt = r_step_pend;
    w_burst_rem_nxt = r_burst_rem;
    w_rst_cnt_nxt   = r_rst_cnt;

    case (r_state)
      ST_PARK: begin
        w_hc_nxt  = '0;
        w_clk_nxt = 1'b0;
        if (w_go) begin
          w_state_nxt = ST_HIGH;
          w_clk_nxt   = 1'b1;
          w_tick_nxt  = 1'b1;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (w_phase_done) begin
          w_state_nxt     = ST_LOW;
          w_hc_nxt        = '0;
          w_clk_nxt       = 1'b0;
          w_step_pend_nxt = 1'b0;
          if (r_burst_rem != '0) w_burst_rem_nxt = r_burst_rem - BURST_W'(1);
        end
      end
      ST_LOW: begin
        if (w_phase_done) begin
          w_hc_nxt = '0;
          if (w_go) begin
            w_state_nxt = ST_HIGH;
            w_clk_nxt   = 1'b1;
            w_tick_nxt  = 1'b1;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end else begin
            w_state_nxt = ST_PARK;
          end
        end
      end
      default: begin
        w_state_nxt = ST_PARK;
        w_hc_nxt    = '0;
        w_clk_nxt   = 1'b0;
      end
    endcase

    // Mode gating is applied last so leaving a mode always drops its request.
    if (mode != MODE_STEP) w_step_pend_nxt = 1'b0;
    else if (w_btn_rise && !r_step_pend) w_step_pend_nxt = 1'b1;

    if (mode != MODE_BURST) w_burst_rem_nxt = '0;
    else if (burst_go && (r_burst_rem == '0) && (burst_len != '0)) w_burst_rem_nxt = burst_len;

    if (rom_sel != r_rom_q) w_rst_cnt_nxt = RW'(RST_EDGES);
    else if (r_tick && (r_rst_cnt != '0)) w_rst_cnt_nxt = r_rst_cnt - RW'(1);
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_state     <= ST_PARK;
      r_hc        <= '0;
      r_clk       <= 1'b0;
      r_tick      <= 1'b0;
      r_cnt       <= '0;
      r_step_pend <= 1'b0;
      r_burst_rem <= '0;
      r_rst_cnt   <= RW'(RST_EDGES);
      r_cpu_rst   <= 1'b1;
      r_rom_q     <= rom_sel;
      r_btn_q     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hc        <= w_hc_nxt;
      r_clk       <= w_clk_nxt;
      r_tick      <= w_tick_nxt;
      r_cnt       <= w_cnt_nxt;
      r_step_pend <= w_step_pend_nxt;
      r_burst_rem <= w_burst_rem_nxt;
      r_rst_cnt   <= w_rst_cnt_nxt;
      r_cpu_rst   <= (w_rst_cnt_nxt != '0);
      r_rom_q     <= rom_sel;
      r_btn_q     <= w_btn_level;
    end
  end

  assign clk_cpu     = r_clk;
  assign cpu_tick    = r_tick;
  assign cpu_rst     = r_cpu_rst;
  assign busy        = (r_state != ST_PARK);
  assign cycle_count = r_cnt;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - directed self-checking bench for cpu_clock_ctrl
module tb_cpu_clock_ctrl;

  logic        clk50M = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [24:0] div_value = 25'd2;
  logic        step_btn = 1'b0;
  logic        burst_go = 1'b0;
  logic [15:0] burst_len = 16'd0;
  logic        rom_sel = 1'b0;
  logic        clk_cpu;
  logic        cpu_tick;
  logic        cpu_rst;
  logic        busy;
  logic [3:0]  cycle_count;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int ticks = 0;
  int highs = 0;

  always #5 clk50M = ~clk50M;

  cpu_clock_ctrl #(
    .CNT_W(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk50M      (clk50M),
    .rst         (rst),
    .mode        (mode),
    .div_value   (div_value),
    .step_btn    (step_btn),
    .burst_go    (burst_go),
    .burst_len   (burst_len),
    .rom_sel     (rom_sel),
    .clk_cpu     (clk_cpu),
    .cpu_tick    (cpu_tick),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50M);
    #1;
    cyc++;
    if (cpu_tick) ticks++;
    if (clk_cpu) highs++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    ticks = 0;
    highs = 0;
  endtask

  initial begin
    // RUN, div 2: reset state, waveform, reset stretch, counter and wrap
    step();
    step();
    chk("rst_clk", 32'(clk_cpu), 0);
    chk("rst_tick", 32'(cpu_tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(cycle_count), 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    rst = 1'b0;
    cyc = 0;
    step();
    chk("run_first_clk", 32'(clk_cpu), 1);
    chk("run_first_tick", 32'(cpu_tick), 1);
    chk("run_first_count", 32'(cycle_count), 1);
    for (int i = 2; i <= 7; i++) begin
      step();
      chk("run_wave_clk", 32'(clk_cpu), 32'((i <= 3) || (i == 7)));
      chk("run_wave_tick", 32'(cpu_tick), 32'(i == 7));
    end
    run_to(19);
    chk("run_cpu_rst_before_4th", 32'(cpu_rst), 1);
    step();
    chk("run_cpu_rst_after_4th", 32'(cpu_rst), 0);
    run_to(55);
    chk("run_count_10", 32'(cycle_count), 10);
    chk("run_tick_10", 32'(cpu_tick), 1);
    run_to(97);
    chk("wrap_count_17", 32'(cycle_count), 1);
    chk("wrap_clk_high", 32'(clk_cpu), 1);
    chk("wrap_cpu_rst", 32'(cpu_rst), 0);
    rst = 1'b1;
    step();
    chk("midrst_clk", 32'(clk_cpu), 0);
    chk("midrst_cpu_rst", 32'(cpu_rst), 1);
    chk("midrst_count", 32'(cycle_count), 0);
    chk("midrst_busy", 32'(busy), 0);

    // rom_sel toggles: stretch, restart mid-stretch, reload beats a same-cycle tick
    mode = 2'd0;
    div_value = 25'd2;
    do_reset();
    run_to(20);
    chk("rom_idle_cpu_rst", 32'(cpu_rst), 0);
    rom_sel = 1'b1;
    step();
    chk("rom_rise", 32'(cpu_rst), 1);
    run_to(43);
    chk("rom_hold_3_ticks", 32'(cpu_rst), 1);
    step();
    chk("rom_fall_4_ticks", 32'(cpu_rst), 0);
    run_to(45);
    rom_sel = 1'b0;
    step();
    chk("rom2_rise", 32'(cpu_rst), 1);
    run_to(55);
    rom_sel = 1'b1;
    run_to(74);
    chk("rom_restart_hold", 32'(cpu_rst), 1);
    run_to(79);
    chk("rom_restart_hold_late", 32'(cpu_rst), 1);
    step();
    chk("rom_restart_fall", 32'(cpu_rst), 0);

    // HALT during a long high phase: both phases finish, then park low
    mode = 2'd0;
    div_value = 25'd10;
    do_reset();
    while (cyc < 22) begin
      step();
      if (cyc == 3) mode = 2'd3;
    end
    chk("halt_busy_low_phase", 32'(busy), 1);
    step();
    chk("halt_parked_busy", 32'(busy), 0);
    chk("halt_parked_clk", 32'(clk_cpu), 0);
    steps(30);
    chk("halt_ticks", 32'(ticks), 1);
    chk("halt_high_cycles", 32'(highs), 11);
    chk("halt_count", 32'(cycle_count), 1);

    // STEP, div 1: bouncing press then stable high gives one 2-cycle pulse
    mode = 2'd1;
    div_value = 25'd1;
    step_btn = 1'b0;
    do_reset();
    for (int g = 0; g < 3; g++) begin
      step_btn = 1'b1;
      steps(3);
      step_btn = 1'b0;
      steps(3);
    end
    chk("step_glitch_ticks", 32'(ticks), 0);
    step_btn = 1'b1;
    steps(40);
    chk("step_ticks", 32'(ticks), 1);
    chk("step_high_cycles", 32'(highs), 2);
    chk("step_busy_after", 32'(busy), 0);
    chk("step_clk_after", 32'(clk_cpu), 0);

    // STEP, div 30: second press accepted during the pulse is dropped
    step_btn = 1'b0;
    div_value = 25'd30;
    do_reset();
    step_btn = 1'b1;
    steps(15);
    step_btn = 1'b0;
    steps(12);
    step_btn = 1'b1;
    steps(100);
    chk("step2_ticks", 32'(ticks), 1);
    chk("step2_high_cycles", 32'(highs), 31);
    chk("step2_busy_after", 32'(busy), 0);
    step_btn = 1'b0;

    // BURST of 5 with a mid-burst retrigger, then a zero-length burst
    mode = 2'd2;
    div_value = 25'd1;
    burst_len = 16'd5;
    do_reset();
    burst_go = 1'b1;
    step();
    burst_go = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      burst_go = (i == 8);
    end
    chk("burst_ticks", 32'(ticks), 5);
    chk("burst_high_cycles", 32'(highs), 10);
    chk("burst_count", 32'(cycle_count), 5);
    chk("burst_busy_after", 32'(busy), 0);
    chk("burst_clk_after", 32'(clk_cpu), 0);
    burst_len = 16'd0;
    ticks = 0;
    burst_go = 1'b1;
    step();
    burst_go = 1'b0;
    steps(20);
    chk("burst0_ticks", 32'(ticks), 0);
    chk("burst0_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
